// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: picks the next-PC source, drives the PC load/stall controls and IF/ID flushes.
// Interrupt entry/return logic (pend latch, EPC, ISR state) is built only with PCCTRL_IRQ_EN defined.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module pc_redirect_ctrl #(
  parameter int          ADDR_W     = `IM_ADDR_BIT,
  parameter int          IRQ_N      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h10,
  parameter logic [31:0] VEC_STRIDE = 32'h4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              eret,
  input  logic              halt,
  input  logic [IRQ_N-1:0]  irq_req,
  output logic              pc_en,
  output logic              pc_stall,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_new,
  output logic              flush_if,
  output logic              flush_id,
  output logic [IRQ_N-1:0]  irq_ack,
  output logic              in_isr,
  output logic [ADDR_W-1:0] epc
);

`ifdef PCCTRL_IRQ_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ISR  = 2'd1,
    ST_HALT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd2
  } state_t;
`endif

  state_t            state_r;
  state_t            state_nxt_s;
  logic              active_s;
  logic              ev_valid_s;
  logic              br_go_s;
  logic              halt_go_s;
  logic              irq_go_s;
  logic              eret_go_s;
  logic              jmp_go_s;
  logic [IRQ_N-1:0]  pick_s;
  logic [IRQ_N-1:0]  ack_s;
  logic [ADDR_W-1:0] vec_addr_s;
  logic [ADDR_W-1:0] ret_addr_s;
  logic              pc_load_s;
  logic              pc_stall_s;
  logic [ADDR_W-1:0] pc_new_s;
  logic              flush_if_s;
  logic              flush_id_s;

`ifdef PCCTRL_IRQ_EN
  logic [IRQ_N-1:0]  pend_r;
  logic [ADDR_W-1:0] epc_r;
  logic              in_isr_r;

  // Isolate the lowest set bit: lower index wins arbitration.
  function automatic logic [IRQ_N-1:0] lowest_one(input logic [IRQ_N-1:0] v);
    lowest_one = v & (~v + IRQ_N'(1));
  endfunction

  function automatic logic [31:0] onehot_idx(input logic [IRQ_N-1:0] oh);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < IRQ_N; i++) begin
      r = r | (oh[i] ? 32'(i) : 32'd0);
    end
    onehot_idx = r;
  endfunction

  // Vector address of the winning pending request and the saved return address
  always_comb begin
    pick_s     = lowest_one(pend_r);
    vec_addr_s = ADDR_W'(VEC_BASE + onehot_idx(pick_s) * VEC_STRIDE);
    ret_addr_s = epc_r;
  end

  // Pending latch, exception PC and ISR flag; everything frozen once halted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r   <= {IRQ_N{1'b0}};
      epc_r    <= {ADDR_W{1'b0}};
      in_isr_r <= 1'b0;
    end else begin
      if (active_s) begin
        pend_r <= (pend_r | irq_req) & ~ack_s;
      end else begin
        pend_r <= pend_r;
      end
      if (halt_go_s) begin
        epc_r <= {ADDR_W{1'b0}};
      end else if (irq_go_s) begin
        epc_r <= pc;
      end else begin
        epc_r <= epc_r;
      end
      in_isr_r <= (state_nxt_s == ST_ISR);
    end
  end

  assign irq_ack = ack_s;
  assign in_isr  = in_isr_r;
  assign epc     = epc_r;
`else
  logic unused_s;

  // No interrupt hardware: vector and return paths are tied off
  always_comb begin
    pick_s     = {IRQ_N{1'b0}};
    vec_addr_s = {ADDR_W{1'b0}};
    ret_addr_s = {ADDR_W{1'b0}};
  end

  assign unused_s = ^{irq_req, eret, pc, ack_s};
  assign irq_ack  = {IRQ_N{1'b0}};
  assign in_isr   = 1'b0;
  assign epc      = {ADDR_W{1'b0}};
`endif

  // Qualify each candidate redirect in priority order
  always_comb begin
    active_s   = (state_r != ST_HALT);
    ev_valid_s = !stall_req && !br_taken;
    br_go_s    = active_s && br_taken;
    halt_go_s  = active_s && ev_valid_s && halt;
`ifdef PCCTRL_IRQ_EN
    irq_go_s   = (state_r == ST_RUN) && ev_valid_s && !halt &&
                 (pend_r != {IRQ_N{1'b0}}) && !jmp && !eret;
    eret_go_s  = (state_r == ST_ISR) && ev_valid_s && !halt && eret;
`else
    irq_go_s   = 1'b0;
    eret_go_s  = 1'b0;
`endif
    jmp_go_s   = active_s && ev_valid_s && !halt && !irq_go_s && !eret_go_s && jmp;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; HALT is left only through reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_go_s) begin
          state_nxt_s = ST_HALT;
        end else if (irq_go_s) begin
`ifdef PCCTRL_IRQ_EN
          state_nxt_s = ST_ISR;
`else
          state_nxt_s = ST_RUN;
`endif
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
`ifdef PCCTRL_IRQ_EN
      ST_ISR: begin
        if (halt_go_s) begin
          state_nxt_s = ST_HALT;
        end else if (eret_go_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_ISR;
        end
      end
`endif
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs: PC controls and flushes; a load always overrides the stall
  always_comb begin
    pc_load_s  = 1'b0;
    pc_new_s   = {ADDR_W{1'b0}};
    pc_stall_s = 1'b0;
    flush_if_s = 1'b0;
    flush_id_s = 1'b0;
    ack_s      = {IRQ_N{1'b0}};
    if (br_go_s) begin
      pc_load_s  = 1'b1;
      pc_new_s   = br_target;
      flush_if_s = 1'b1;
      flush_id_s = 1'b1;
    end else if (halt_go_s) begin
      pc_load_s  = 1'b0;
    end else if (irq_go_s) begin
      pc_load_s  = 1'b1;
      pc_new_s   = vec_addr_s;
      flush_if_s = 1'b1;
      ack_s      = pick_s;
    end else if (eret_go_s) begin
      pc_load_s  = 1'b1;
      pc_new_s   = ret_addr_s;
      flush_if_s = 1'b1;
    end else if (jmp_go_s) begin
      pc_load_s  = 1'b1;
      pc_new_s   = jmp_target;
      flush_if_s = 1'b1;
    end else begin
      pc_stall_s = active_s && stall_req;
    end
  end

  assign pc_en    = active_s;
  assign pc_load  = pc_load_s;
  assign pc_new   = pc_new_s;
  assign pc_stall = pc_stall_s;
  assign flush_if = flush_if_s;
  assign flush_id = flush_id_s;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Table-driven plus hand-sequenced checks for pc_redirect_ctrl (ADDR_W=10, IRQ_N=4).
// Interrupt sequences are checked when PCCTRL_IRQ_EN is defined, the tied-off behaviour otherwise.
module tb_pc_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pc, br_target, jmp_target;
  logic       stall_req, br_taken, jmp, eret, halt;
  logic [3:0] irq_req;
  logic       pc_en, pc_stall, pc_load, flush_if, flush_id, in_isr;
  logic [9:0] pc_new, epc;
  logic [3:0] irq_ack;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       stall_req, br_taken, jmp, eret, halt;
    logic [3:0] irq;
    logic [9:0] pc, br_target, jmp_target;
    logic       e_en, e_stall, e_load, e_fif, e_fid, e_isr;
    logic [9:0] e_new, e_epc;
    logic [3:0] e_ack;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[8];
  vec_t v;

  pc_redirect_ctrl #(.ADDR_W(10), .IRQ_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .stall_req(stall_req),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .eret(eret), .halt(halt), .irq_req(irq_req),
    .pc_en(pc_en), .pc_stall(pc_stall), .pc_load(pc_load), .pc_new(pc_new),
    .flush_if(flush_if), .flush_id(flush_id), .irq_ack(irq_ack),
    .in_isr(in_isr), .epc(epc)
  );

  always #5 clk = ~clk;

  function automatic vec_t idle_v(input string nm);
    vec_t r;
    r.name = nm;
    r.stall_req = 1'b0; r.br_taken = 1'b0; r.jmp = 1'b0; r.eret = 1'b0; r.halt = 1'b0;
    r.irq = 4'h0; r.pc = 10'h0; r.br_target = 10'h0; r.jmp_target = 10'h0;
    r.e_en = 1'b1; r.e_stall = 1'b0; r.e_load = 1'b0; r.e_fif = 1'b0; r.e_fid = 1'b0;
    r.e_isr = 1'b0; r.e_new = 10'h0; r.e_epc = 10'h0; r.e_ack = 4'h0;
    return r;
  endfunction

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(input vec_t s);
    vec_t e;
    stall_req = s.stall_req; br_taken = s.br_taken; jmp = s.jmp; eret = s.eret;
    halt = s.halt; irq_req = s.irq; pc = s.pc; br_target = s.br_target;
    jmp_target = s.jmp_target;
    exp_q.push_back(s);
    #4;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.scoreboard got=empty want=entry", s.name);
    end else begin
      e = exp_q.pop_front();
      chk(e.name, "pc_en",    32'(pc_en),    32'(e.e_en));
      chk(e.name, "pc_stall", 32'(pc_stall), 32'(e.e_stall));
      chk(e.name, "pc_load",  32'(pc_load),  32'(e.e_load));
      chk(e.name, "pc_new",   32'(pc_new),   32'(e.e_new));
      chk(e.name, "flush_if", 32'(flush_if), 32'(e.e_fif));
      chk(e.name, "flush_id", 32'(flush_id), 32'(e.e_fid));
      chk(e.name, "irq_ack",  32'(irq_ack),  32'(e.e_ack));
      chk(e.name, "in_isr",   32'(in_isr),   32'(e.e_isr));
      chk(e.name, "epc",      32'(epc),      32'(e.e_epc));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_req = 1'b0; br_taken = 1'b0; jmp = 1'b0; eret = 1'b0; halt = 1'b0;
    irq_req = 4'h0; pc = 10'h0; br_target = 10'h0; jmp_target = 10'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = idle_v("idle");
    tbl[1] = idle_v("br_over_jmp_stall");
    tbl[1].br_taken = 1'b1; tbl[1].br_target = 10'h40; tbl[1].jmp = 1'b1; tbl[1].stall_req = 1'b1;
    tbl[1].jmp_target = 10'h155;
    tbl[1].e_load = 1'b1; tbl[1].e_new = 10'h40; tbl[1].e_fif = 1'b1; tbl[1].e_fid = 1'b1;
    tbl[2] = idle_v("stall_blocks_jmp");
    tbl[2].stall_req = 1'b1; tbl[2].jmp = 1'b1; tbl[2].jmp_target = 10'h1a5; tbl[2].e_stall = 1'b1;
    tbl[3] = idle_v("jmp_after_stall");
    tbl[3].jmp = 1'b1; tbl[3].jmp_target = 10'h1a5;
    tbl[3].e_load = 1'b1; tbl[3].e_new = 10'h1a5; tbl[3].e_fif = 1'b1;
    tbl[4] = idle_v("stall_only");
    tbl[4].stall_req = 1'b1; tbl[4].e_stall = 1'b1;
    tbl[5] = idle_v("br_over_halt");
    tbl[5].br_taken = 1'b1; tbl[5].halt = 1'b1; tbl[5].br_target = 10'h3ff;
    tbl[5].e_load = 1'b1; tbl[5].e_new = 10'h3ff; tbl[5].e_fif = 1'b1; tbl[5].e_fid = 1'b1;
    tbl[6] = idle_v("eret_in_run_noop");
    tbl[6].eret = 1'b1; tbl[6].jmp_target = 10'h2aa;
    tbl[7] = idle_v("jmp_with_eret_in_run");
    tbl[7].eret = 1'b1; tbl[7].jmp = 1'b1; tbl[7].jmp_target = 10'h2aa;
    tbl[7].e_load = 1'b1; tbl[7].e_new = 10'h2aa; tbl[7].e_fif = 1'b1;

    do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(tbl[i]);

`ifdef PCCTRL_IRQ_EN
    v = idle_v("irq_pulse");   v.irq = 4'b0110; v.pc = 10'h23; step(v);
    v = idle_v("irq1_entry");  v.pc = 10'h23;
    v.e_ack = 4'b0010; v.e_load = 1'b1; v.e_new = 10'h14; v.e_fif = 1'b1; step(v);
    v = idle_v("isr_no_nest"); v.pc = 10'h14; v.e_isr = 1'b1; v.e_epc = 10'h23; step(v);
    v = idle_v("eret");        v.pc = 10'h15; v.eret = 1'b1;
    v.e_isr = 1'b1; v.e_epc = 10'h23; v.e_load = 1'b1; v.e_new = 10'h23; v.e_fif = 1'b1; step(v);
    v = idle_v("irq2_entry");  v.pc = 10'h24;
    v.e_epc = 10'h23; v.e_ack = 4'b0100; v.e_load = 1'b1; v.e_new = 10'h18; v.e_fif = 1'b1; step(v);
    v = idle_v("isr2");        v.pc = 10'h18; v.e_isr = 1'b1; v.e_epc = 10'h24; step(v);
    v = idle_v("isr_req0");    v.pc = 10'h19; v.irq = 4'b0001; v.e_isr = 1'b1; v.e_epc = 10'h24; step(v);
    v = idle_v("isr_jmp");     v.pc = 10'h1a; v.jmp = 1'b1; v.jmp_target = 10'h30;
    v.e_isr = 1'b1; v.e_epc = 10'h24; v.e_load = 1'b1; v.e_new = 10'h30; v.e_fif = 1'b1; step(v);
    v = idle_v("eret2");       v.pc = 10'h30; v.eret = 1'b1;
    v.e_isr = 1'b1; v.e_epc = 10'h24; v.e_load = 1'b1; v.e_new = 10'h24; v.e_fif = 1'b1; step(v);
    v = idle_v("jmp_over_irq"); v.pc = 10'h24; v.jmp = 1'b1; v.jmp_target = 10'h77;
    v.e_epc = 10'h24; v.e_load = 1'b1; v.e_new = 10'h77; v.e_fif = 1'b1; step(v);
    v = idle_v("irq0_entry");  v.pc = 10'h77;
    v.e_epc = 10'h24; v.e_ack = 4'b0001; v.e_load = 1'b1; v.e_new = 10'h10; v.e_fif = 1'b1; step(v);
    v = idle_v("isr3_req3");   v.pc = 10'h10; v.irq = 4'b1000; v.e_isr = 1'b1; v.e_epc = 10'h77; step(v);
    do_reset();
    v = idle_v("post_reset_isr"); step(v);
    v = idle_v("pend_discarded"); step(v);
`else
    v = idle_v("irq_eret_ignored"); v.irq = 4'hf; v.eret = 1'b1; v.pc = 10'h23; step(v);
    v = idle_v("no_entry");     v.pc = 10'h23; step(v);
    v = idle_v("eret_noop");    v.eret = 1'b1; v.irq = 4'hf; step(v);
    v = idle_v("still_idle");   step(v);
`endif

    v = idle_v("halt_req");     v.halt = 1'b1; v.pc = 10'h50; step(v);
    v = idle_v("halted_inputs"); v.jmp = 1'b1; v.jmp_target = 10'h1; v.br_taken = 1'b1;
    v.br_target = 10'h2; v.irq = 4'hf; v.e_en = 1'b0; step(v);
    v = idle_v("halted_stall"); v.stall_req = 1'b1; v.eret = 1'b1; v.e_en = 1'b0; step(v);
    do_reset();
    v = idle_v("post_halt_reset"); step(v);
    v = idle_v("post_halt_jmp"); v.jmp = 1'b1; v.jmp_target = 10'h33;
    v.e_load = 1'b1; v.e_new = 10'h33; v.e_fif = 1'b1; step(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
